// File: rtl/sd_sector_host.sv
// rtl/sd_sector_host.sv - moves one 512-byte sector between a core sector buffer and 16-bit block memory
module sd_sector_host #(
    parameter int ADDR_W = 24
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [31:0]       sd_lba,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic [7:0]        sd_buff_addr,
    output logic [15:0]       sd_buff_dout,
    output logic              sd_buff_wr,
    input  logic [15:0]       sd_buff_din,
    input  logic [31:0]       img_sectors,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_busy,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_rvalid
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_CMD  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_ADDR = 3'd3;
    localparam logic [2:0] S_WR_CMD  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]  state_q, state_d;
    logic        rd_prev_q, wr_prev_q;
    logic [31:0] lba_q, lba_d;
    logic [7:0]  idx_q, idx_d;
    logic        ack_q, ack_d;
    logic [7:0]  baddr_q, baddr_d;
    logic [15:0] bdout_q, bdout_d;
    logic        bwr_q, bwr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        wr_pend_q, wr_pend_d;

    logic rd_rise, wr_rise, oor, last;

    assign rd_rise = sd_rd & ~rd_prev_q;
    assign wr_rise = sd_wr & ~wr_prev_q;
    assign oor     = (lba_q >= img_sectors);
    assign last    = (idx_q == 8'hFF);

    // Commands come straight from registered state, so they cannot move while mem_busy holds them.
    assign mem_rd       = (state_q == S_RD_CMD) && !oor;
    assign mem_wr       = (state_q == S_WR_CMD) && wr_pend_q && !oor;
    assign mem_addr     = ADDR_W'({lba_q, 8'h00}) + ADDR_W'(idx_q);
    assign mem_wdata    = wdata_q;
    assign sd_ack       = ack_q;
    assign sd_buff_addr = baddr_q;
    assign sd_buff_dout = bdout_q;
    assign sd_buff_wr   = bwr_q;

    always_comb begin
        state_d   = state_q;
        lba_d     = lba_q;
        idx_d     = idx_q;
        ack_d     = ack_q;
        baddr_d   = baddr_q;
        bdout_d   = bdout_q;
        bwr_d     = 1'b0;
        wdata_d   = wdata_q;
        wr_pend_d = wr_pend_q;
        case (state_q)
            S_IDLE: begin
                if (rd_rise) begin
                    lba_d   = sd_lba;
                    idx_d   = 8'd0;
                    ack_d   = 1'b1;
                    state_d = S_RD_CMD;
                end else if (wr_rise) begin
                    lba_d   = sd_lba;
                    idx_d   = 8'd0;
                    ack_d   = 1'b1;
                    baddr_d = 8'd0;
                    state_d = S_WR_ADDR;
                end
            end
            S_RD_CMD: begin
                if (oor) begin
                    bwr_d   = 1'b1;
                    bdout_d = 16'h0000;
                    baddr_d = idx_q;
                    idx_d   = idx_q + 8'd1;
                    state_d = last ? S_DONE : S_RD_CMD;
                end else if (!mem_busy) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (mem_rvalid) begin
                    bwr_d   = 1'b1;
                    bdout_d = mem_rdata;
                    baddr_d = idx_q;
                    idx_d   = idx_q + 8'd1;
                    state_d = last ? S_DONE : S_RD_CMD;
                end
            end
            S_WR_ADDR: state_d = S_WR_CMD;
            S_WR_CMD: begin
                // First WR_CMD cycle waits for the buffer's registered read of the new address.
                if (!wr_pend_q) begin
                    wdata_d   = sd_buff_din;
                    wr_pend_d = 1'b1;
                end else if (oor || !mem_busy) begin
                    wr_pend_d = 1'b0;
                    idx_d     = idx_q + 8'd1;
                    baddr_d   = idx_q + 8'd1;
                    state_d   = last ? S_DONE : S_WR_ADDR;
                end
            end
            S_DONE: begin
                ack_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            rd_prev_q <= 1'b0;
            wr_prev_q <= 1'b0;
            lba_q     <= 32'd0;
            idx_q     <= 8'd0;
            ack_q     <= 1'b0;
            baddr_q   <= 8'd0;
            bdout_q   <= 16'd0;
            bwr_q     <= 1'b0;
            wdata_q   <= 16'd0;
            wr_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_prev_q <= sd_rd;
            wr_prev_q <= sd_wr;
            lba_q     <= lba_d;
            idx_q     <= idx_d;
            ack_q     <= ack_d;
            baddr_q   <= baddr_d;
            bdout_q   <= bdout_d;
            bwr_q     <= bwr_d;
            wdata_q   <= wdata_d;
            wr_pend_q <= wr_pend_d;
        end
    end

endmodule

// File: tb/tb_sd_sector_host.sv
// tb/tb_sd_sector_host.sv - vector table plus random transfers checked against a sector-level model
module tb_sd_sector_host;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] sd_lba = 32'd0;
    logic        sd_rd = 1'b0;
    logic        sd_wr = 1'b0;
    logic        sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout;
    logic        sd_buff_wr;
    logic [15:0] sd_buff_din = 16'd0;
    logic [31:0] img_sectors = 32'd0;
    logic [23:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_wdata;
    logic        mem_busy;
    logic [15:0] mem_rdata = 16'd0;
    logic        mem_rvalid = 1'b0;

    always #5 clk_sys = ~clk_sys;

    sd_sector_host #(.ADDR_W(24)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .img_sectors(img_sectors),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_busy(mem_busy), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    int total = 0;
    int bad = 0;
    int bp_max = 0;
    int busy_cnt = 0;
    logic [15:0] wbase = 16'd0;

    // Memory answers with its own address one cycle after accept; core buffer word = wbase + index.
    assign mem_busy = (mem_rd | mem_wr) && (busy_cnt < bp_max);
    always @(posedge clk_sys) begin
        busy_cnt    <= ((mem_rd | mem_wr) && mem_busy) ? busy_cnt + 1 : 0;
        mem_rvalid  <= mem_rd && !mem_busy;
        mem_rdata   <= mem_addr[15:0];
        sd_buff_din <= wbase + {8'h00, sd_buff_addr};
    end

    logic [23:0] strb_q[$];
    logic [23:0] rd_addr_q[$];
    logic [39:0] wr_q[$];
    int          collide = 0;
    int          unstable = 0;
    logic        hold_v = 1'b0;
    logic [41:0] hold_val = '0;

    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (sd_buff_wr) strb_q.push_back({sd_buff_addr, sd_buff_dout});
            if (mem_rd && !mem_busy) rd_addr_q.push_back(mem_addr);
            if (mem_wr && !mem_busy) wr_q.push_back({mem_addr, mem_wdata});
            if (mem_rd && mem_wr) collide++;
            if (hold_v && ({mem_rd, mem_wr, mem_addr, mem_wdata} != hold_val)) unstable++;
            hold_v   = (mem_rd | mem_wr) && mem_busy;
            hold_val = {mem_rd, mem_wr, mem_addr, mem_wdata};
        end else begin
            hold_v = 1'b0;
        end
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_ctrl"}, {36'd0, sd_ack, sd_buff_wr, mem_rd, mem_wr, sd_buff_addr, sd_buff_dout}, 64'd0);
        check({nm, "_mem"}, {24'd0, mem_addr, mem_wdata}, 64'd0);
    endtask

    task automatic clear_mon();
        strb_q.delete();
        rd_addr_q.delete();
        wr_q.delete();
        collide  = 0;
        unstable = 0;
    endtask

    task automatic wait_ack_low();
        int n = 0;
        while (sd_ack && n < 3000) begin
            @(negedge clk_sys);
            n++;
        end
        check("ack_timeout", {63'd0, sd_ack}, 64'd0);
    endtask

    task automatic run_xfer(input bit rd, input bit wr, input logic [31:0] lba, input logic [31:0] img,
                            input int bp, input logic [15:0] wb, input int e_str, input int e_rd, input int e_wr);
        bit oor;
        logic [39:0] a;
        logic [15:0] ed;
        @(posedge clk_sys);
        img_sectors = img;
        bp_max      = bp;
        wbase       = wb;
        sd_lba      = lba;
        clear_mon();
        @(negedge clk_sys);
        sd_rd = rd;
        sd_wr = wr;
        @(negedge clk_sys);
        check("ack_start", {63'd0, sd_ack}, 64'd1);
        sd_rd  = 1'b0;
        sd_wr  = 1'b0;
        sd_lba = $urandom;
        wait_ack_low();
        repeat (4) @(negedge clk_sys);
        check("no_retrigger", {63'd0, sd_ack}, 64'd0);
        oor = (lba >= img);
        check("strobe_count", strb_q.size(), e_str);
        check("rd_accepts", rd_addr_q.size(), e_rd);
        check("wr_accepts", wr_q.size(), e_wr);
        for (int i = 0; i < strb_q.size() && i < 256; i++) begin
            a  = {lba, 8'h00} + 40'(i);
            ed = (rd && !oor) ? a[15:0] : 16'h0000;
            check("strobe_word", strb_q[i], {i[7:0], ed});
        end
        for (int i = 0; i < rd_addr_q.size() && i < 256; i++) begin
            a = {lba, 8'h00} + 40'(i);
            check("rd_addr", rd_addr_q[i], a[23:0]);
        end
        for (int i = 0; i < wr_q.size() && i < 256; i++) begin
            a = {lba, 8'h00} + 40'(i);
            check("wr_word", wr_q[i], {a[23:0], wb + 16'(i)});
        end
        check("cmd_collision", collide, 0);
        check("busy_stability", unstable, 0);
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] lba;
        logic [31:0] img;
        int          bp;
        logic [15:0] wb;
        int          e_str;
        int          e_rd;
        int          e_wr;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'd3, 32'd100, 0, 16'h0000, 256, 256, 0};
        vecs[1] = '{1'b0, 1'b1, 32'd5, 32'd100, 0, 16'hA500, 0, 0, 256};
        vecs[2] = '{1'b1, 1'b0, 32'd4, 32'd4, 0, 16'h0000, 256, 0, 0};
        vecs[3] = '{1'b0, 1'b1, 32'd4, 32'd4, 0, 16'h1234, 0, 0, 0};
        vecs[4] = '{1'b1, 1'b0, 32'd5, 32'd100, 3, 16'h0000, 256, 256, 0};
        vecs[5] = '{1'b0, 1'b1, 32'd7, 32'd100, 3, 16'h5A00, 0, 0, 256};
        vecs[6] = '{1'b1, 1'b1, 32'd2, 32'd100, 0, 16'h7700, 256, 256, 0};
        vecs[7] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 16'h0000, 256, 0, 0};
        vecs[8] = '{1'b1, 1'b0, 32'h0001_2345, 32'h8000_0000, 1, 16'h0000, 256, 256, 0};
        vecs[9] = '{1'b0, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2, 16'hC0DE, 0, 0, 256};

        repeat (3) @(negedge clk_sys);
        check_zero("reset_state");
        reset_n = 1'b1;

        foreach (vecs[k])
            run_xfer(vecs[k].rd, vecs[k].wr, vecs[k].lba, vecs[k].img, vecs[k].bp, vecs[k].wb,
                     vecs[k].e_str, vecs[k].e_rd, vecs[k].e_wr);

        for (int r = 0; r < 6; r++) begin
            bit          rd;
            bit          oor;
            logic [31:0] lba, img;
            rd  = 1'($urandom_range(0, 1));
            img = 32'($urandom_range(1, 64));
            lba = 32'($urandom_range(0, 80));
            oor = (lba >= img);
            run_xfer(rd, !rd, lba, img, $urandom_range(0, 3), 16'($urandom),
                     rd ? 256 : 0, (rd && !oor) ? 256 : 0, (!rd && !oor) ? 256 : 0);
        end

        begin
            int n = 0;
            @(posedge clk_sys);
            img_sectors = 32'd100;
            sd_lba      = 32'd3;
            bp_max      = 0;
            clear_mon();
            @(negedge clk_sys);
            sd_rd = 1'b1;
            @(negedge clk_sys);
            sd_rd = 1'b0;
            while (!(sd_buff_wr && sd_buff_addr == 8'd100) && n < 2000) begin
                @(negedge clk_sys);
                n++;
            end
            check("word100_reached", {63'd0, n < 2000}, 64'd1);
            reset_n = 1'b0;
            #1;
            check_zero("reset_mid");
            repeat (2) @(negedge clk_sys);
            reset_n = 1'b1;
        end
        run_xfer(1'b1, 1'b0, 32'd3, 32'd100, 0, 16'h0000, 256, 256, 0);

        @(negedge clk_sys);
        reset_n = 1'b0;
        sd_rd   = 1'b1;
        sd_lba  = 32'd9;
        clear_mon();
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        check("ack_after_release", {63'd0, sd_ack}, 64'd1);
        sd_rd = 1'b0;
        wait_ack_low();
        check("release_strobes", strb_q.size(), 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_sector_host.md
SD_SECTOR_HOST -- requirements
Module: sd_sector_host

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, giving the 16-bit-word address width of the backing memory.
REQ-002 SHALL have port clk_sys, input, 1: the single clock; all logic is rising-edge.
REQ-003 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port sd_lba, input, 32: sector number of the request, sampled at request start.
REQ-005 SHALL have port sd_rd, input, 1: sector read request (block memory to core).
REQ-006 SHALL have port sd_wr, input, 1: sector write request (core to block memory).
REQ-007 SHALL have port sd_ack, output, 1: transfer in progress.
REQ-008 SHALL have port sd_buff_addr, output, 8: word index into the core sector buffer.
REQ-009 SHALL have port sd_buff_dout, output, 16: read data to the core.
REQ-010 SHALL have port sd_buff_wr, output, 1: one-cycle strobe; sd_buff_dout is valid at sd_buff_addr.
REQ-011 SHALL have port sd_buff_din, input, 16: core buffer data, valid one cycle after sd_buff_addr changes.
REQ-012 SHALL have port img_sectors, input, 32: image size in 512-byte sectors.
REQ-013 SHALL have port mem_addr, output, ADDR_W: word address, equal to {sd_lba,8'b0} + index, truncated to ADDR_W.
REQ-014 SHALL have ports mem_rd and mem_wr, outputs, 1 each: memory commands, held while mem_busy is high.
REQ-015 SHALL have port mem_wdata, output, 16: memory write data.
REQ-016 SHALL have port mem_busy, input, 1: waitrequest; a command is accepted on a cycle where it is high and mem_busy is low.
REQ-017 SHALL have ports mem_rdata (input, 16) and mem_rvalid (input, 1): read return; one read is outstanding at a time.

Function
REQ-018 SHALL implement the states IDLE, RD_CMD, RD_WAIT, WR_ADDR, WR_CMD and DONE.
REQ-019 SHALL start a request in IDLE only on a rising edge of sd_rd or sd_wr, detected against their values registered on the previous cycle.
REQ-020 SHALL give sd_rd priority when sd_rd and sd_wr rise on the same cycle; the ignored sd_wr needs a fresh rising edge to be served.
REQ-021 SHALL latch sd_lba on the start cycle, clear the 8-bit index, and assert sd_ack on the next cycle.
REQ-022 SHALL treat a request as out of range when the latched lba >= img_sectors, using an unsigned 32-bit compare.
REQ-023 Read path, per word:
- RD_CMD: assert mem_rd until accepted, then go to RD_WAIT.
- RD_WAIT: on mem_rvalid, set sd_buff_dout = mem_rdata and sd_buff_addr = index, and pulse sd_buff_wr for one cycle.
- Then increment the index and return to RD_CMD.
REQ-024 SHALL, for an out-of-range read, issue no mem_rd and emit 256 sd_buff_wr strobes of 16'h0000, one per cycle.
REQ-025 Write path, per word:
- WR_ADDR: drive sd_buff_addr = index for one cycle.
- WR_CMD: capture sd_buff_din into mem_wdata and assert mem_wr until accepted.
- Then increment the index.
REQ-026 SHALL, for an out-of-range write, walk the indexes with the same timing but issue no mem_wr.
REQ-027 SHALL enter DONE after index 255 completes; DONE deasserts sd_ack on the next cycle and returns to IDLE.
REQ-028 SHALL never assert mem_rd and mem_wr together, and SHALL keep mem_addr, mem_wdata and the commands stable while mem_busy is high.
REQ-029 SHALL ignore sd_rd, sd_wr and sd_lba changes while sd_ack is high.
REQ-030 SHALL not wrap the index during a transfer; 8-bit index overflow only occurs at DONE.
REQ-031 SHALL wrap the mem_addr arithmetic modulo 2^ADDR_W.

Reset
REQ-032 SHALL, while reset_n is low, force state IDLE, and drive sd_ack, sd_buff_wr, mem_rd and mem_wr to 0, and sd_buff_addr, sd_buff_dout, mem_addr, mem_wdata and the index to 0.
REQ-033 SHALL, on reset mid-transfer, abandon the transfer without completion.
REQ-034 SHALL clear the registered sd_rd/sd_wr history in reset, so that a request line already high at reset release counts as a rising edge.

Verification
REQ-035 Read, in range:
- Stimulus: img_sectors=100, sd_lba=3, sd_rd pulse, memory returns word = address[15:0], mem_busy low, 1-cycle latency.
- Response: mem_addr runs 0x300..0x3FF; 256 strobes with sd_buff_dout = 0x0300+i at addr i; sd_ack drops after the last strobe.
REQ-036 Write, in range:
- Stimulus: sd_lba=5, core buffer word i = 16'hA500+i.
- Response: 256 mem_wr with mem_addr = 0x500+i and mem_wdata = 0xA500+i, in order.
REQ-037 Out of range:
- Stimulus: img_sectors=4, sd_lba=4, then a read followed by a write.
- Response: read gives 256 zero strobes and no mem_rd; write gives no mem_wr; sd_ack still pulses for each.
REQ-038 Backpressure:
- Stimulus: mem_busy high for 3 cycles on every command.
- Response: commands, address and data stay stable while busy; exactly one accept per word; all 256 words are correct.
REQ-039 Simultaneous requests and reset:
- sd_rd and sd_wr rise together: only the read is served.
- reset_n low at word 100: all outputs are 0 on the same edge.
- A new sd_rd after release: a full 256-word transfer from index 0.
